fir_stream_param: RTL and testbench

//  Parametrised streaming direct-form FIR filter, the successor to the fixed 4-tap/4-bit filter.

---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_stream_param_if.sv | 40 ++++
 rtl/fir_tap.sv | 51 +++++
 rtl/fir_stream_param.sv | 96 +++++++++
 tb/tb_fir_stream_param.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, types and helpers for the streaming FIR filter.
//   DEF_*      default widths / tap count used by the filter and its interface
//   sample_t   default-width input sample
//   coef_t     default-width coefficient
//   product_t  full-precision sample*coef product at default widths
//   out_width  overflow-free result width: DATA_W + COEF_W + clog2(TAPS)
package fir_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_COEF_W = 4;
    localparam int DEF_TAPS   = 4;

    typedef logic [DEF_DATA_W-1:0]            sample_t;
    typedef logic [DEF_COEF_W-1:0]            coef_t;
    typedef logic [DEF_DATA_W+DEF_COEF_W-1:0] product_t;

    function automatic int out_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_stream_param_if.sv
// fir_stream_param_if: sample stream, result stream, coefficient port and flush
// of the streaming FIR filter.
//   in_valid/in_ready/in_data     input sample handshake
//   out_valid/out_ready/y         result handshake
//   coef_we/coef_addr/coef_data   coefficient write port
//   flush                         synchronous clear of delay line and pipeline
// modport slave  : filter side
// modport master : sample source / consumer / control side
interface fir_stream_param_if
    import fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int TAPS   = DEF_TAPS
);
    localparam int OUT_W  = out_width(DATA_W, COEF_W, TAPS);
    localparam int ADDR_W = $clog2(TAPS);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  y;
    logic              coef_we;
    logic [ADDR_W-1:0] coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              flush;

    modport slave (
        input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_data, flush,
        output in_ready, out_valid, y
    );

    modport master (
        output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data, flush,
        input  in_ready, out_valid, y
    );

endinterface

// File: rtl/fir_tap.sv
// fir_tap: one FIR tap -- delay register, coefficient register, registered product.
//   CLK, RST_N  clock, asynchronous active-low reset
//   en          stage-1 advance (pipeline not stalled)
//   shift       accepted sample: load d_q from d_in
//   flush       clear delay register and product (coefficient kept)
//   coef_we     write coef_data into this tap's coefficient
//   d_in        previous tap's delayed sample (or the new sample for tap 0)
//   d_q         this tap's delayed sample, feeds the next tap
//   prod_q      registered d_q * coef, full precision
module fir_tap
    import fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     en,
    input  logic                     shift,
    input  logic                     flush,
    input  logic                     coef_we,
    input  logic [COEF_W-1:0]        coef_data,
    input  logic [DATA_W-1:0]        d_in,
    output logic [DATA_W-1:0]        d_q,
    output logic [DATA_W+COEF_W-1:0] prod_q
);
    localparam int PROD_W = DATA_W + COEF_W;

    logic [COEF_W-1:0] coef_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            d_q    <= '0;
            coef_q <= '0;
            prod_q <= '0;
        end else begin
            if (flush)
                d_q <= '0;
            else if (shift)
                d_q <= d_in;
            // coefficient writes go through even while the pipeline is stalled
            if (coef_we)
                coef_q <= coef_data;
            if (flush)
                prod_q <= '0;
            else if (en)
                prod_q <= PROD_W'(d_q) * PROD_W'(coef_q);
        end
    end

endmodule

// File: rtl/fir_stream_param.sv
// fir_stream_param: parametrised streaming direct-form FIR filter.
//   y = sum_k d[k]*coef[k], d[0] newest accepted sample, unsigned full precision.
//   CLK, RST_N  clock, asynchronous active-low reset
//   s           fir_stream_param_if.slave: sample/result handshakes, coef port, flush
// Timing: sample accepted at edge E -> products at E+1 -> y/out_valid at E+2.
// A stalled output (out_valid && !out_ready) freezes delay line, products and y.
module fir_stream_param
    import fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int TAPS   = DEF_TAPS
) (
    input  logic             CLK,
    input  logic             RST_N,
    fir_stream_param_if.slave s
);
    localparam int OUT_W  = out_width(DATA_W, COEF_W, TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ADDR_W = $clog2(TAPS);
    localparam int STAGES = 2;

    logic                           stall;
    logic                           en;
    logic                           accept;
    logic [TAPS-1:0][DATA_W-1:0]    d_line;
    logic [TAPS-1:0][PROD_W-1:0]    prod;
    logic [OUT_W-1:0]               sum;
    logic [OUT_W-1:0]               y_q;
    // [0]: delay line holds a freshly accepted sample, [1]: products valid, [2]: y valid
    logic [STAGES:0]                vld_pipe;

    assign stall       = vld_pipe[STAGES] && !s.out_ready;
    assign en          = !stall;
    // a sample offered in a flush cycle is dropped
    assign accept      = s.in_valid && en && !s.flush;
    assign s.in_ready  = en;
    assign s.out_valid = vld_pipe[STAGES];
    assign s.y         = y_q;
    assign d_line[0]   = s.in_data;

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        logic we;
        assign we = s.coef_we && (s.coef_addr == ADDR_W'(k));

        if (k < TAPS-1) begin : g_mid
            fir_tap #(.DATA_W(DATA_W), .COEF_W(COEF_W)) u_tap (
                .CLK       (CLK),
                .RST_N     (RST_N),
                .en        (en),
                .shift     (accept),
                .flush     (s.flush),
                .coef_we   (we),
                .coef_data (s.coef_data),
                .d_in      (d_line[k]),
                .d_q       (d_line[k+1]),
                .prod_q    (prod[k])
            );
        end else begin : g_last
            // the oldest sample falls off the end of the delay line here
            logic [DATA_W-1:0] oldest_unused;
            fir_tap #(.DATA_W(DATA_W), .COEF_W(COEF_W)) u_tap (
                .CLK       (CLK),
                .RST_N     (RST_N),
                .en        (en),
                .shift     (accept),
                .flush     (s.flush),
                .coef_we   (we),
                .coef_data (s.coef_data),
                .d_in      (d_line[k]),
                .d_q       (oldest_unused),
                .prod_q    (prod[k])
            );
        end
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < TAPS; k++)
            sum = sum + OUT_W'(prod[k]);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_pipe <= '0;
            y_q      <= '0;
        end else if (s.flush) begin
            vld_pipe <= '0;
            y_q      <= '0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], accept};
            y_q      <= sum;
        end
    end

endmodule

// File: tb/tb_fir_stream_param.sv
// tb_fir_stream_param: directed self-checking bench for fir_stream_param.
//   u_a: default 4/4/4 filter (impulse, max value, bubbles, backpressure,
//        coefficient update, flush, async reset)
//   u_b: 8/8/8 filter (max value in 19-bit result)
//   u_c: 4/4/3 filter (coefficient address beyond the last tap)
module tb_fir_stream_param;
    import fir_pkg::*;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    fir_stream_param_if #(.DATA_W(4), .COEF_W(4), .TAPS(4)) a_if ();
    fir_stream_param_if #(.DATA_W(8), .COEF_W(8), .TAPS(8)) b_if ();
    fir_stream_param_if #(.DATA_W(4), .COEF_W(4), .TAPS(3)) c_if ();

    fir_stream_param #(.DATA_W(4), .COEF_W(4), .TAPS(4)) u_a (.CLK(CLK), .RST_N(RST_N), .s(a_if));
    fir_stream_param #(.DATA_W(8), .COEF_W(8), .TAPS(8)) u_b (.CLK(CLK), .RST_N(RST_N), .s(b_if));
    fir_stream_param #(.DATA_W(4), .COEF_W(4), .TAPS(3)) u_c (.CLK(CLK), .RST_N(RST_N), .s(c_if));

    int checks = 0;
    int errors = 0;
    int q[$];

    int t1_exp[5] = '{1, 2, 3, 4, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // every result handed to the consumer of u_a, in order
    always @(negedge CLK)
        if (a_if.out_valid === 1'b1 && a_if.out_ready === 1'b1)
            q.push_back(int'(a_if.y));

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic set_coef(input int k, input int v);
        a_if.coef_we   = 1'b1;
        a_if.coef_addr = 2'(k);
        a_if.coef_data = 4'(v);
        step();
        a_if.coef_we   = 1'b0;
    endtask

    task automatic load4(input int c0, input int c1, input int c2, input int c3);
        set_coef(0, c0);
        set_coef(1, c1);
        set_coef(2, c2);
        set_coef(3, c3);
    endtask

    task automatic do_flush();
        a_if.flush = 1'b1;
        step();
        a_if.flush = 1'b0;
    endtask

    // feed back-to-back samples to u_a with no stall expected
    task automatic feed(input int s);
        a_if.in_valid = 1'b1;
        a_if.in_data  = 4'(s);
        step();
        a_if.in_valid = 1'b0;
    endtask

    task automatic chk_q(input string tag, input int n, input int exp[5]);
        chk({tag, "_count"}, q.size(), n);
        for (int j = 0; j < n; j++)
            chk($sformatf("%s_y%0d", tag, j), (j < q.size()) ? q[j] : -1, exp[j]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0;
        a_if.in_valid = 0; a_if.in_data = 0; a_if.out_ready = 1; a_if.coef_we = 0;
        a_if.coef_addr = 0; a_if.coef_data = 0; a_if.flush = 0;
        b_if.in_valid = 0; b_if.in_data = 0; b_if.out_ready = 1; b_if.coef_we = 0;
        b_if.coef_addr = 0; b_if.coef_data = 0; b_if.flush = 0;
        c_if.in_valid = 0; c_if.in_data = 0; c_if.out_ready = 1; c_if.coef_we = 0;
        c_if.coef_addr = 0; c_if.coef_data = 0; c_if.flush = 0;
        #12;
        chk("rst_out_valid", a_if.out_valid, 0);
        chk("rst_y", a_if.y, 0);
        chk("rst_in_ready", a_if.in_ready, 1);
        @(negedge CLK);
        RST_N = 1'b1;
        step();

        // 1. impulse, latency E+2
        load4(1, 2, 3, 4);
        q.delete();
        for (int i = 0; i < 5; i++) begin
            a_if.in_valid = 1'b1;
            a_if.in_data  = (i == 0) ? 4'd1 : 4'd0;
            step();
            if (i == 1) begin
                @(negedge CLK);
                chk("t1_lat_e1_ov", a_if.out_valid, 0);
            end
            if (i == 2) begin
                @(negedge CLK);
                chk("t1_lat_e2_ov", a_if.out_valid, 1);
                chk("t1_lat_e2_y", a_if.y, 1);
            end
        end
        a_if.in_valid = 1'b0;
        idle(6);
        chk_q("t1", 5, t1_exp);

        // 2. max value, default widths
        load4(15, 15, 15, 15);
        do_flush();
        q.delete();
        for (int i = 0; i < 4; i++) feed(15);
        idle(5);
        chk("t2_count", q.size(), 4);
        chk("t2_first", (q.size() > 0) ? q[0] : -1, 225);
        chk("t2_max", (q.size() > 3) ? q[3] : -1, 900);

        // 2b. max value, 8 taps of 8x8 bits
        for (int k = 0; k < 8; k++) begin
            b_if.coef_we = 1'b1; b_if.coef_addr = 3'(k); b_if.coef_data = 8'hFF;
            step();
        end
        b_if.coef_we = 1'b0;
        b_if.in_valid = 1'b1; b_if.in_data = 8'hFF;
        idle(8);
        b_if.in_valid = 1'b0;
        idle(2);
        @(negedge CLK);
        chk("t2b_ov", b_if.out_valid, 1);
        chk("t2b_y", b_if.y, 520200);

        // 3. bubbles do not advance the delay line
        load4(1, 2, 3, 4);
        do_flush();
        q.delete();
        for (int i = 0; i < 4; i++) begin
            feed((i == 0) ? 1 : 0);
            idle(3);
        end
        idle(4);
        chk_q("t3", 4, t1_exp);

        // 4. backpressure while y=2 is presented
        do_flush();
        q.delete();
        for (int i = 0; i < 4; i++) feed((i == 0) ? 1 : 0);
        a_if.out_ready = 1'b0;
        a_if.in_valid  = 1'b1;
        a_if.in_data   = 4'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk($sformatf("t4_hold_y%0d", i), a_if.y, 2);
            chk($sformatf("t4_hold_ov%0d", i), a_if.out_valid, 1);
            chk($sformatf("t4_hold_rdy%0d", i), a_if.in_ready, 0);
            step();
        end
        a_if.out_ready = 1'b1;
        step();
        a_if.in_valid = 1'b0;
        idle(6);
        chk_q("t4", 5, t1_exp);

        // 5. coefficient update mid-stream
        load4(1, 1, 1, 1);
        do_flush();
        a_if.in_valid = 1'b1;
        a_if.in_data  = 4'd1;
        idle(6);
        @(negedge CLK);
        chk("t5_base", a_if.y, 4);
        a_if.coef_we = 1'b1; a_if.coef_addr = 2'd2; a_if.coef_data = 4'd5;
        step();
        a_if.coef_we = 1'b0;
        step();
        @(negedge CLK);
        chk("t5_old_coef", a_if.y, 4);
        step();
        @(negedge CLK);
        chk("t5_new_coef", a_if.y, 8);

        // 5b. write beyond the last tap is ignored
        for (int k = 0; k < 4; k++) begin
            c_if.coef_we = 1'b1; c_if.coef_addr = 2'(k); c_if.coef_data = (k < 3) ? 4'd1 : 4'd15;
            step();
        end
        c_if.coef_we = 1'b0;
        c_if.in_valid = 1'b1; c_if.in_data = 4'd1;
        idle(6);
        @(negedge CLK);
        chk("t5b_ov", c_if.out_valid, 1);
        chk("t5b_y", c_if.y, 3);
        c_if.in_valid = 1'b0;

        // 6. flush mid-stream, in_valid held high through the flush cycle
        @(negedge CLK);
        chk("t6_pre", a_if.y, 8);
        a_if.flush = 1'b1;
        step();
        a_if.flush = 1'b0;
        @(negedge CLK);
        chk("t6_flush_ov", a_if.out_valid, 0);
        chk("t6_flush_y", a_if.y, 0);
        step();
        @(negedge CLK);
        chk("t6_f1_ov", a_if.out_valid, 0);
        step();
        @(negedge CLK);
        chk("t6_f2_ov", a_if.out_valid, 0);
        step();
        @(negedge CLK);
        chk("t6_f3_ov", a_if.out_valid, 1);
        chk("t6_f3_y", a_if.y, 1);
        step();
        @(negedge CLK);
        chk("t6_f4_y", a_if.y, 2);
        step();
        @(negedge CLK);
        chk("t6_f5_y", a_if.y, 7);
        step();
        @(negedge CLK);
        chk("t6_f6_y", a_if.y, 8);

        // 6b. asynchronous reset mid-cycle
        @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        chk("t6_rst_ov", a_if.out_valid, 0);
        chk("t6_rst_y", a_if.y, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("t6_rst_rdy", a_if.in_ready, 1);
        idle(4);
        @(negedge CLK);
        chk("t6_post_ov", a_if.out_valid, 1);
        chk("t6_post_coef_lost", a_if.y, 0);
        a_if.in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
